// File: rtl/branch_resolver.sv
// Purpose: captures the comparator result word into {lt,eq,gt} flags and answers branch-condition queries.
// Latency: br_ack pulses in the cycle after the 2nd edge once br_req is seen with flags available.
// Backpressure: cmp_ready drops only while a decision is being resolved; br_req waits in WAIT until flags exist.
module branch_resolver #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       cmp_y,
   input  logic             cmp_valid,
   output logic             cmp_ready,
   input  logic             br_req,
   input  logic [2:0]       br_cond,
   output logic             br_ack,
   output logic             br_taken,
   output logic [2:0]       flags,
   output logic             flags_valid,
   output logic             cmp_err,
   output logic [CNT_W-1:0] br_count
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_RESOLVE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   localparam logic [2:0] C_EQ     = 3'b000;
   localparam logic [2:0] C_NE     = 3'b001;
   localparam logic [2:0] C_GT     = 3'b010;
   localparam logic [2:0] C_LT     = 3'b011;
   localparam logic [2:0] C_GE     = 3'b100;
   localparam logic [2:0] C_LE     = 3'b101;
   localparam logic [2:0] C_ALWAYS = 3'b110;
   localparam logic [2:0] C_NEVER  = 3'b111;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [2:0]       r_flags;
   logic             r_flags_valid;
   logic             r_cmp_err;
   logic             r_br_ack;
   logic             r_br_taken;
   logic [CNT_W-1:0] r_br_count;

   logic             w_xfer;
   logic             w_well_formed;
   logic             w_good_cap;
   logic             w_cond_hit;

   // Flags are frozen while a decision is computed, so the input is only stalled in RESOLVE.
   assign cmp_ready     = (r_state != S_RESOLVE);
   assign w_xfer        = cmp_valid & cmp_ready;
   assign w_well_formed = (cmp_y[7:3] == 5'd0) &&
                          ((cmp_y[2:0] == 3'b001) || (cmp_y[2:0] == 3'b010) || (cmp_y[2:0] == 3'b100));
   assign w_good_cap    = w_xfer & w_well_formed;

   // Evaluate the requested condition against the registered {lt, eq, gt} flags.
   always_comb begin
      w_cond_hit = 1'b0;
      case (br_cond)
         C_EQ:     w_cond_hit = r_flags[1];
         C_NE:     w_cond_hit = ~r_flags[1];
         C_GT:     w_cond_hit = r_flags[0];
         C_LT:     w_cond_hit = r_flags[2];
         C_GE:     w_cond_hit = r_flags[0] | r_flags[1];
         C_LE:     w_cond_hit = r_flags[2] | r_flags[1];
         C_ALWAYS: w_cond_hit = 1'b1;
         C_NEVER:  w_cond_hit = 1'b0;
         default:  w_cond_hit = 1'b0;
      endcase
   end

   // Next-state logic; a well-formed capture on the request edge counts as flags being available.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (br_req) begin
               if (r_flags_valid || w_good_cap) w_state_nxt = S_RESOLVE;
               else                             w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_good_cap) w_state_nxt = S_RESOLVE;
         end
         S_RESOLVE: begin
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (!br_req) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register; reset abandons any query in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Flag capture: malformed words complete the handshake but only raise the sticky error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_flags       <= 3'b000;
         r_flags_valid <= 1'b0;
         r_cmp_err     <= 1'b0;
      end else if (w_xfer) begin
         if (w_well_formed) begin
            r_flags       <= cmp_y[2:0];
            r_flags_valid <= 1'b1;
         end else begin
            r_cmp_err     <= 1'b1;
         end
      end
   end

   // Decision outputs: one-cycle ack, held taken bit, wrapping completion counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_br_ack   <= 1'b0;
         r_br_taken <= 1'b0;
         r_br_count <= '0;
      end else if (r_state == S_RESOLVE) begin
         r_br_ack   <= 1'b1;
         r_br_taken <= w_cond_hit;
         r_br_count <= r_br_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_br_ack   <= 1'b0;
      end
   end

   assign br_ack      = r_br_ack;
   assign br_taken    = r_br_taken;
   assign flags       = r_flags;
   assign flags_valid = r_flags_valid;
   assign cmp_err     = r_cmp_err;
   assign br_count    = r_br_count;

endmodule

// File: tb/tb_branch_resolver.sv
// Purpose: directed self-checking bench for branch_resolver.
// Latency: inputs change 1 time unit after each rising edge; outputs sampled at the same point.
// Backpressure: exercises cmp_ready stall in RESOLVE and br_req waiting for flags.
module tb_branch_resolver;

   logic       clk;
   logic       rst_n;
   logic [7:0] cmp_y;
   logic       cmp_valid;
   logic       cmp_ready;
   logic       br_req;
   logic [2:0] br_cond;
   logic       br_ack;
   logic       br_taken;
   logic [2:0] flags;
   logic       flags_valid;
   logic       cmp_err;
   logic [7:0] br_count;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_count;

   branch_resolver #(.CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmp_y       (cmp_y),
      .cmp_valid   (cmp_valid),
      .cmp_ready   (cmp_ready),
      .br_req      (br_req),
      .br_cond     (br_cond),
      .br_ack      (br_ack),
      .br_taken    (br_taken),
      .flags       (flags),
      .flags_valid (flags_valid),
      .cmp_err     (cmp_err),
      .br_count    (br_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Condition table: flags are {lt, eq, gt}.
   function automatic logic exp_taken(input logic [2:0] c, input logic [2:0] f);
      case (c)
         3'd0: return f[1];
         3'd1: return ~f[1];
         3'd2: return f[0];
         3'd3: return f[2];
         3'd4: return f[0] | f[1];
         3'd5: return f[2] | f[1];
         3'd6: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst_n = 1'b0; cmp_valid = 1'b0; br_req = 1'b0; cmp_y = 8'h00; br_cond = 3'd0;
      tick; tick;
      rst_n = 1'b1;
      exp_count = 8'd0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; cmp_valid = 1'b0; br_req = 1'b0; cmp_y = 8'h00; br_cond = 3'd0;
      tick; tick;
      n_checks++; if (cmp_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ready got=%0b exp=1", cmp_ready); end
      n_checks++; if (br_ack !== 1'b0)      begin n_fail++; $display("FAIL reset_ack got=%0b exp=0", br_ack); end
      n_checks++; if (br_taken !== 1'b0)    begin n_fail++; $display("FAIL reset_taken got=%0b exp=0", br_taken); end
      n_checks++; if (flags !== 3'b000)     begin n_fail++; $display("FAIL reset_flags got=%b exp=000", flags); end
      n_checks++; if (flags_valid !== 1'b0) begin n_fail++; $display("FAIL reset_flags_valid got=%0b exp=0", flags_valid); end
      n_checks++; if (cmp_err !== 1'b0)     begin n_fail++; $display("FAIL reset_cmp_err got=%0b exp=0", cmp_err); end
      n_checks++; if (br_count !== 8'd0)    begin n_fail++; $display("FAIL reset_count got=%0d exp=0", br_count); end
      rst_n = 1'b1;
      exp_count = 8'd0;
      tick;
   endtask

   task automatic test_capture_query;
      cmp_y = 8'h01; cmp_valid = 1'b1;
      tick;
      cmp_valid = 1'b0; cmp_y = 8'h00;
      n_checks++; if (flags !== 3'b001)     begin n_fail++; $display("FAIL cap_flags got=%b exp=001", flags); end
      n_checks++; if (flags_valid !== 1'b1) begin n_fail++; $display("FAIL cap_flags_valid got=%0b exp=1", flags_valid); end
      // GT query: ack after two edges
      br_req = 1'b1; br_cond = 3'd2;
      tick;
      n_checks++; if (br_ack !== 1'b0)      begin n_fail++; $display("FAIL gt_ack_early got=%0b exp=0", br_ack); end
      n_checks++; if (cmp_ready !== 1'b0)   begin n_fail++; $display("FAIL gt_ready_resolve got=%0b exp=0", cmp_ready); end
      tick;
      exp_count = exp_count + 8'd1;
      n_checks++; if (br_ack !== 1'b1)      begin n_fail++; $display("FAIL gt_ack got=%0b exp=1", br_ack); end
      n_checks++; if (br_taken !== 1'b1)    begin n_fail++; $display("FAIL gt_taken got=%0b exp=1", br_taken); end
      n_checks++; if (br_count !== exp_count) begin n_fail++; $display("FAIL gt_count got=%0d exp=%0d", br_count, exp_count); end
      tick;
      n_checks++; if (br_ack !== 1'b0)      begin n_fail++; $display("FAIL gt_ack_pulse got=%0b exp=0", br_ack); end
      n_checks++; if (br_taken !== 1'b1)    begin n_fail++; $display("FAIL gt_taken_hold got=%0b exp=1", br_taken); end
      br_req = 1'b0;
      tick;
      // LE query against gt flags: not taken
      br_req = 1'b1; br_cond = 3'd5;
      tick; tick;
      exp_count = exp_count + 8'd1;
      n_checks++; if (br_ack !== 1'b1)      begin n_fail++; $display("FAIL le_ack got=%0b exp=1", br_ack); end
      n_checks++; if (br_taken !== 1'b0)    begin n_fail++; $display("FAIL le_taken got=%0b exp=0", br_taken); end
      n_checks++; if (br_count !== exp_count) begin n_fail++; $display("FAIL le_count got=%0d exp=%0d", br_count, exp_count); end
      br_req = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid_query;
      br_req = 1'b1; br_cond = 3'd2;
      tick;
      n_checks++; if (cmp_ready !== 1'b0)   begin n_fail++; $display("FAIL midrst_in_resolve got=%0b exp=0", cmp_ready); end
      rst_n = 1'b0;
      tick;
      exp_count = 8'd0;
      n_checks++; if (br_ack !== 1'b0)      begin n_fail++; $display("FAIL midrst_ack got=%0b exp=0", br_ack); end
      n_checks++; if (br_count !== 8'd0)    begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", br_count); end
      n_checks++; if (cmp_ready !== 1'b1)   begin n_fail++; $display("FAIL midrst_ready got=%0b exp=1", cmp_ready); end
      rst_n = 1'b1; br_req = 1'b0;
      tick;
      n_checks++; if (br_ack !== 1'b0)      begin n_fail++; $display("FAIL midrst_ack_after got=%0b exp=0", br_ack); end
   endtask

   task automatic test_malformed;
      apply_reset;
      br_req = 1'b1; br_cond = 3'd1;
      tick; tick;
      cmp_y = 8'h03; cmp_valid = 1'b1;
      tick;
      n_checks++; if (cmp_err !== 1'b1)     begin n_fail++; $display("FAIL bad03_err got=%0b exp=1", cmp_err); end
      n_checks++; if (flags_valid !== 1'b0) begin n_fail++; $display("FAIL bad03_flags_valid got=%0b exp=0", flags_valid); end
      cmp_y = 8'h80;
      tick;
      cmp_valid = 1'b0; cmp_y = 8'h00;
      n_checks++; if (flags !== 3'b000)     begin n_fail++; $display("FAIL bad80_flags got=%b exp=000", flags); end
      n_checks++; if (flags_valid !== 1'b0) begin n_fail++; $display("FAIL bad80_flags_valid got=%0b exp=0", flags_valid); end
      n_checks++; if (cmp_ready !== 1'b1)   begin n_fail++; $display("FAIL bad_wait_ready got=%0b exp=1", cmp_ready); end
      tick; tick;
      n_checks++; if (br_ack !== 1'b0)      begin n_fail++; $display("FAIL bad_wait_ack got=%0b exp=0", br_ack); end
      // a good word now releases the pending NE query: gt flags -> taken
      cmp_y = 8'h01; cmp_valid = 1'b1;
      tick;
      cmp_valid = 1'b0; cmp_y = 8'h00;
      tick;
      exp_count = exp_count + 8'd1;
      n_checks++; if (br_ack !== 1'b1)      begin n_fail++; $display("FAIL bad_release_ack got=%0b exp=1", br_ack); end
      n_checks++; if (br_taken !== 1'b1)    begin n_fail++; $display("FAIL bad_release_taken got=%0b exp=1", br_taken); end
      n_checks++; if (cmp_err !== 1'b1)     begin n_fail++; $display("FAIL err_sticky got=%0b exp=1", cmp_err); end
      br_req = 1'b0;
      tick;
   endtask

   task automatic test_wait;
      logic seen;
      apply_reset;
      br_req = 1'b1; br_cond = 3'd0;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick;
         if (br_ack === 1'b1) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0)        begin n_fail++; $display("FAIL wait_no_ack got=%0b exp=0", seen); end
      cmp_y = 8'h02; cmp_valid = 1'b1;
      tick;
      cmp_valid = 1'b0; cmp_y = 8'h00;
      n_checks++; if (br_ack !== 1'b0)      begin n_fail++; $display("FAIL wait_ack_early got=%0b exp=0", br_ack); end
      tick;
      exp_count = exp_count + 8'd1;
      n_checks++; if (br_ack !== 1'b1)      begin n_fail++; $display("FAIL wait_ack got=%0b exp=1", br_ack); end
      n_checks++; if (br_taken !== 1'b1)    begin n_fail++; $display("FAIL wait_taken got=%0b exp=1", br_taken); end
      n_checks++; if (br_count !== exp_count) begin n_fail++; $display("FAIL wait_count got=%0d exp=%0d", br_count, exp_count); end
      br_req = 1'b0;
      tick;
   endtask

   task automatic test_simultaneous;
      cmp_y = 8'h01; cmp_valid = 1'b1;
      tick;
      cmp_valid = 1'b0;
      n_checks++; if (flags !== 3'b001)     begin n_fail++; $display("FAIL sim_pre_flags got=%b exp=001", flags); end
      cmp_y = 8'h04; cmp_valid = 1'b1; br_req = 1'b1; br_cond = 3'd3;
      tick;
      n_checks++; if (flags !== 3'b100)     begin n_fail++; $display("FAIL sim_flags got=%b exp=100", flags); end
      n_checks++; if (cmp_ready !== 1'b0)   begin n_fail++; $display("FAIL sim_ready got=%0b exp=0", cmp_ready); end
      // offer a word during RESOLVE; it must not be taken
      cmp_y = 8'h01; cmp_valid = 1'b1;
      tick;
      cmp_valid = 1'b0; cmp_y = 8'h00;
      exp_count = exp_count + 8'd1;
      n_checks++; if (br_ack !== 1'b1)      begin n_fail++; $display("FAIL sim_ack got=%0b exp=1", br_ack); end
      n_checks++; if (br_taken !== 1'b1)    begin n_fail++; $display("FAIL sim_taken got=%0b exp=1", br_taken); end
      n_checks++; if (flags !== 3'b100)     begin n_fail++; $display("FAIL sim_frozen got=%b exp=100", flags); end
      n_checks++; if (br_count !== exp_count) begin n_fail++; $display("FAIL sim_count got=%0d exp=%0d", br_count, exp_count); end
      br_req = 1'b0;
      tick;
   endtask

   task automatic test_wrap_sweep;
      logic [2:0] f;
      logic [2:0] c;
      logic       et;
      apply_reset;
      for (int i = 0; i < 256; i++) begin
         f = 3'b001 << ((i / 8) % 3);
         c = 3'(i % 8);
         et = exp_taken(c, f);
         cmp_y = {5'b00000, f}; cmp_valid = 1'b1; br_req = 1'b1; br_cond = c;
         tick;
         cmp_valid = 1'b0;
         tick;
         exp_count = exp_count + 8'd1;
         n_checks++; if (br_ack !== 1'b1)   begin n_fail++; $display("FAIL sweep_ack i=%0d got=%0b exp=1", i, br_ack); end
         n_checks++; if (br_taken !== et)   begin n_fail++; $display("FAIL sweep_taken i=%0d cond=%0d flags=%b got=%0b exp=%0b", i, c, f, br_taken, et); end
         n_checks++; if (br_count !== exp_count) begin n_fail++; $display("FAIL sweep_count i=%0d got=%0d exp=%0d", i, br_count, exp_count); end
         br_req = 1'b0;
         tick;
      end
      n_checks++; if (br_count !== 8'd0)    begin n_fail++; $display("FAIL wrap_count got=%0d exp=0", br_count); end
   endtask

   initial begin
      rst_n = 1'b0; cmp_y = 8'h00; cmp_valid = 1'b0; br_req = 1'b0; br_cond = 3'd0;
      exp_count = 8'd0;
      test_reset;
      test_capture_query;
      test_reset_mid_query;
      test_malformed;
      test_wait;
      test_simultaneous;
      test_wrap_sweep;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
